// File: rtl/ddr_avl_arbiter_if.sv
// Bundle of the requester-side and controller-side Avalon-MM signals of the DDR arbiter.
// No latency: wires only.
// Handshake is wait_request_n (ready) on commands and readdatavalid on responses.
interface ddr_avl_arbiter_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 128
);
  // requester side
  logic [1:0]             rq_read;
  logic [1:0]             rq_write;
  logic [1:0][ADDR_W-1:0] rq_address;
  logic [1:0][DATA_W-1:0] rq_writedata;
  logic [1:0]             rq_wait_request_n;
  logic [1:0]             rq_readdatavalid;
  logic [DATA_W-1:0]      rq_readdata;
  // controller side
  logic [ADDR_W-1:0]      avl_address;
  logic                   avl_read;
  logic                   avl_write;
  logic [DATA_W-1:0]      avl_writedata;
  logic                   avl_burstbegin;
  logic                   avl_wait_request_n;
  logic                   avl_readdatavalid;
  logic [DATA_W-1:0]      avl_readdata;

  // the arbiter: Avalon master towards the controller, target of the requesters
  modport master (
    input  rq_read, rq_write, rq_address, rq_writedata,
    output rq_wait_request_n, rq_readdatavalid, rq_readdata,
    output avl_address, avl_read, avl_write, avl_writedata, avl_burstbegin,
    input  avl_wait_request_n, avl_readdatavalid, avl_readdata
  );

  // the environment: requesters plus DDR controller
  modport slave (
    output rq_read, rq_write, rq_address, rq_writedata,
    input  rq_wait_request_n, rq_readdatavalid, rq_readdata,
    input  avl_address, avl_read, avl_write, avl_writedata, avl_burstbegin,
    output avl_wait_request_n, avl_readdatavalid, avl_readdata
  );
endinterface

// File: rtl/ddr_avl_arbiter.sv
// Two-requester round-robin arbiter onto one Avalon-MM DDR port; read responses routed by in-order tag FIFO.
// Latency: 1 cycle arbitration then command presented; responses routed combinationally.
// Backpressure: avl_wait_request_n passed to the granted requester; reads held off while MAX_OUT tags are outstanding.
module ddr_avl_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 128,
  parameter int MAX_OUT = 8
) (
  input  logic                iCLK,
  input  logic                reset,
  ddr_avl_arbiter_if.master   bus,
  output logic                err
);

  localparam int PTR_W = $clog2(MAX_OUT);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               gnt;
  logic               gnt_nxt;
  logic               rr_ptr;

  logic [MAX_OUT-1:0] tag_mem;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  logic [1:0]         elig;
  logic               cmd_rd;
  logic               cmd_wr;
  logic               conflict;
  logic               drop;
  logic               accept;

  assign fifo_full  = (count == (PTR_W+1)'(MAX_OUT));
  assign fifo_empty = (count == '0);

  // a read can only win arbitration if its tag has somewhere to go
  assign elig = bus.rq_write | (bus.rq_read & {2{~fifo_full}});

  // decode the granted requester's command; read wins over a simultaneous write
  always_comb begin
    cmd_rd   = 1'b0;
    cmd_wr   = 1'b0;
    conflict = 1'b0;
    drop     = 1'b0;
    if (state == GRANT) begin
      cmd_rd   = bus.rq_read[gnt] & ~fifo_full;
      cmd_wr   = bus.rq_write[gnt] & ~bus.rq_read[gnt];
      conflict = bus.rq_read[gnt] & bus.rq_write[gnt];
      drop     = ~(bus.rq_read[gnt] | bus.rq_write[gnt]);
    end
  end

  assign accept = (cmd_rd | cmd_wr) & bus.avl_wait_request_n;
  assign push   = accept & cmd_rd;
  assign pop    = bus.avl_readdatavalid & ~fifo_empty;

  // next-state: pick a requester in IDLE, leave GRANT on accept or when the requester gives up
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    case (state)
      IDLE: begin
        if (|elig) begin
          gnt_nxt   = (&elig) ? rr_ptr : elig[1];
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (accept || drop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // command port mirrors the granted requester; everything idles outside GRANT
  always_comb begin
    bus.avl_address       = '0;
    bus.avl_writedata     = '0;
    bus.avl_read          = 1'b0;
    bus.avl_write         = 1'b0;
    bus.avl_burstbegin    = 1'b0;
    bus.rq_wait_request_n = 2'b00;
    if (state == GRANT) begin
      bus.avl_address    = bus.rq_address[gnt];
      bus.avl_writedata  = bus.rq_writedata[gnt];
      bus.avl_read       = cmd_rd;
      bus.avl_write      = cmd_wr;
      bus.avl_burstbegin = cmd_rd | cmd_wr;
      // never signal acceptance of a read that is being held for a free tag
      bus.rq_wait_request_n[gnt] = bus.avl_wait_request_n & ~(bus.rq_read[gnt] & fifo_full);
    end
  end

  // response routing: oldest outstanding tag owns the returning beat
  always_comb begin
    bus.rq_readdatavalid = 2'b00;
    bus.rq_readdata      = '0;
    if (pop) begin
      bus.rq_readdatavalid[tag_mem[rd_ptr]] = 1'b1;
      bus.rq_readdata                       = bus.avl_readdata;
    end
  end

  // state, grant and round-robin pointer
  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      if (accept) begin
        rr_ptr <= ~gnt;
      end
    end
  end

  // tag FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

  // tag storage needs no reset: validity is tracked by the pointers
  always_ff @(posedge iCLK) begin
    if (push) begin
      tag_mem[wr_ptr] <= gnt;
    end
  end

  // sticky protocol error: abandoned grant, read+write together, or an unexpected response
  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((state == GRANT && (drop || conflict)) ||
                 (bus.avl_readdatavalid && fifo_empty)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_avl_arbiter.sv
// Self-checking bench for ddr_avl_arbiter: directed scenarios plus randomized traffic.
// Reference model tracks the grant, round-robin preference and outstanding tags as a queue.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
module tb_ddr_avl_arbiter;

  localparam int ADDR_W  = 26;
  localparam int DATA_W  = 128;
  localparam int MAX_OUT = 8;

  logic iCLK;
  logic reset;
  logic err;

  ddr_avl_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ddr_avl_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .iCLK  (iCLK),
    .reset (reset),
    .bus   (bus),
    .err   (err)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int cur    = -1;   // granted requester, -1 when none
  int prefer = 0;    // requester favoured when both are eligible
  int q[$];          // outstanding read tags, oldest first
  bit m_err  = 1'b0;
  int acc    = -1;   // requester the model saw accepted in the last step
  int obs_acc = -1;  // requester the DUT signalled as accepted in the last step

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    cur    = -1;
    prefer = 0;
    q.delete();
    m_err  = 1'b0;
    acc    = -1;
  endtask

  // one clock: compare outputs against the model, then advance the model across the edge
  task automatic step();
    logic [1:0]        r;
    logic [1:0]        w;
    bit                full;
    logic              e_rd;
    logic              e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic [1:0]        e_wrn;
    logic [1:0]        e_rdv;
    int                n_cur;
    int                push_tag;
    @(negedge iCLK);
    r      = bus.rq_read;
    w      = bus.rq_write;
    full   = (q.size() == MAX_OUT);
    e_rd   = 1'b0;
    e_wr   = 1'b0;
    e_addr = '0;
    e_data = '0;
    e_wrn  = 2'b00;
    e_rdv  = 2'b00;
    if (cur >= 0) begin
      e_addr     = bus.rq_address[cur];
      e_data     = bus.rq_writedata[cur];
      e_rd       = r[cur] && !full;
      e_wr       = w[cur] && !r[cur];
      e_wrn[cur] = bus.avl_wait_request_n && !(r[cur] && full);
    end
    if (bus.avl_readdatavalid && q.size() > 0) e_rdv[q[0]] = 1'b1;

    check_val("avl_read", bus.avl_read, e_rd);
    check_val("avl_write", bus.avl_write, e_wr);
    check_val("avl_burstbegin", bus.avl_burstbegin, e_rd | e_wr);
    check_val("avl_address", bus.avl_address, e_addr);
    check_val("avl_writedata", bus.avl_writedata, e_data);
    check_val("rq_wait_request_n", bus.rq_wait_request_n, e_wrn);
    check_val("rq_readdatavalid", bus.rq_readdatavalid, e_rdv);
    if (e_rdv != 2'b00) check_val("rq_readdata", bus.rq_readdata, bus.avl_readdata);
    check_val("err", err, m_err);

    obs_acc = -1;
    if ((bus.avl_read || bus.avl_write) && bus.avl_wait_request_n) begin
      if (bus.rq_wait_request_n[1]) obs_acc = 1;
      else if (bus.rq_wait_request_n[0]) obs_acc = 0;
    end

    acc      = -1;
    n_cur    = cur;
    push_tag = -1;
    if (cur < 0) begin
      bit el0, el1;
      el0 = w[0] || (r[0] && !full);
      el1 = w[1] || (r[1] && !full);
      if (el0 && el1) n_cur = prefer;
      else if (el0)   n_cur = 0;
      else if (el1)   n_cur = 1;
    end else begin
      if (r[cur] && w[cur]) m_err = 1'b1;
      if ((e_rd || e_wr) && bus.avl_wait_request_n) begin
        acc    = cur;
        prefer = 1 - cur;
        if (e_rd) push_tag = cur;
        n_cur  = -1;
      end else if (!r[cur] && !w[cur]) begin
        m_err = 1'b1;
        n_cur = -1;
      end
    end
    if (bus.avl_readdatavalid) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_err = 1'b1;
    end
    if (push_tag >= 0) q.push_back(push_tag);

    @(posedge iCLK);
    cur = n_cur;
    #1;
  endtask

  task automatic clear_inputs();
    bus.rq_read            = 2'b00;
    bus.rq_write           = 2'b00;
    bus.rq_address         = '0;
    bus.rq_writedata       = '0;
    bus.avl_wait_request_n = 1'b1;
    bus.avl_readdatavalid  = 1'b0;
    bus.avl_readdata       = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    @(posedge iCLK);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  // present one command from requester i and hold it until the DUT accepts it
  task automatic issue(input int i, input bit rd, input logic [ADDR_W-1:0] a);
    bit got;
    got = 1'b0;
    bus.rq_address[i] = a;
    bus.rq_writedata[i] = {4{$urandom}};
    bus.rq_read[i]  = rd;
    bus.rq_write[i] = !rd;
    for (int k = 0; k < 8; k++) begin
      step();
      if (obs_acc == i) begin
        got = 1'b1;
        break;
      end
    end
    check_val("issue_accepted", got, 1'b1);
    bus.rq_read[i]  = 1'b0;
    bus.rq_write[i] = 1'b0;
  endtask

  int gseq[$];
  bit has[2];
  bit isrd[2];
  bit iswr[2];

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #2;
    check_val("rst_avl_read", bus.avl_read, 1'b0);
    check_val("rst_avl_write", bus.avl_write, 1'b0);
    check_val("rst_avl_address", bus.avl_address, '0);
    check_val("rst_rq_wrn", bus.rq_wait_request_n, 2'b00);
    check_val("rst_err", err, 1'b0);
    @(posedge iCLK);
    #1;
    reset = 1'b0;

    // single read from requester 0 and its response
    bus.rq_read       = 2'b01;
    bus.rq_address[0] = 26'h10;
    step();
    check_val("t1_avl_read", bus.avl_read, 1'b1);
    check_val("t1_avl_address", bus.avl_address, 26'h10);
    step();
    bus.rq_read = 2'b00;
    check_val("t1_idle_after_accept", bus.avl_read, 1'b0);
    bus.avl_readdatavalid = 1'b1;
    bus.avl_readdata      = {16{8'hA5}};
    #1;
    check_val("t1_rdv", bus.rq_readdatavalid, 2'b01);
    check_val("t1_rdata", bus.rq_readdata, {16{8'hA5}});
    step();
    bus.avl_readdatavalid = 1'b0;

    // both requesters writing back to back: grants alternate
    apply_reset();
    bus.rq_write      = 2'b11;
    bus.rq_address[0] = 26'h100;
    bus.rq_address[1] = 26'h200;
    gseq.delete();
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.avl_write && bus.rq_wait_request_n != 2'b00)
        gseq.push_back((bus.avl_address == 26'h200) ? 1 : 0);
    end
    bus.rq_write = 2'b00;
    check_val("t2_grant_count", gseq.size(), 4);
    for (int k = 0; k < gseq.size() && k < 4; k++)
      check_val("t2_grant_order", gseq[k], k % 2);
    step();

    // controller stalls a write from requester 1 for 5 cycles
    apply_reset();
    bus.rq_write           = 2'b10;
    bus.rq_address[1]      = 26'h3AB;
    bus.rq_writedata[1]    = {4{32'hDEADBEEF}};
    bus.avl_wait_request_n = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      check_val("t3_hold_write", bus.avl_write, 1'b1);
      check_val("t3_hold_addr", bus.avl_address, 26'h3AB);
      check_val("t3_hold_wrn", bus.rq_wait_request_n, 2'b00);
      step();
    end
    bus.avl_wait_request_n = 1'b1;
    #1;
    check_val("t3_release_wrn", bus.rq_wait_request_n, 2'b10);
    step();
    bus.rq_write = 2'b00;
    check_val("t3_done", bus.avl_write, 1'b0);

    // eight outstanding reads block a ninth until a response returns
    apply_reset();
    for (int n = 0; n < MAX_OUT; n++) issue(0, 1'b1, ADDR_W'(n));
    bus.rq_read       = 2'b01;
    bus.rq_address[0] = 26'h55;
    bus.rq_write      = 2'b10;
    bus.rq_address[1] = 26'h77;
    step();
    check_val("t4_write_granted", bus.avl_write, 1'b1);
    check_val("t4_read_blocked", bus.avl_read, 1'b0);
    step();
    bus.rq_write = 2'b00;
    step();
    check_val("t4_still_blocked", bus.avl_read, 1'b0);
    bus.avl_readdatavalid = 1'b1;
    step();
    bus.avl_readdatavalid = 1'b0;
    check_val("t4_blocked_on_pop", bus.avl_read, 1'b0);
    step();
    check_val("t4_read_issues", bus.avl_read, 1'b1);
    check_val("t4_read_addr", bus.avl_address, 26'h55);
    step();
    bus.rq_read = 2'b00;

    // interleaved reads route back in order; push and pop in one cycle
    apply_reset();
    issue(0, 1'b1, 26'h1);
    issue(1, 1'b1, 26'h2);
    bus.rq_read       = 2'b01;
    bus.rq_address[0] = 26'h3;
    step();
    bus.avl_readdatavalid = 1'b1;
    bus.avl_readdata      = {4{32'h11111111}};
    #1;
    check_val("t5_rdv0", bus.rq_readdatavalid, 2'b01);
    step();
    bus.rq_read = 2'b00;
    bus.avl_readdata = {4{32'h22222222}};
    #1;
    check_val("t5_rdv1", bus.rq_readdatavalid, 2'b10);
    step();
    bus.avl_readdata = {4{32'h33333333}};
    #1;
    check_val("t5_rdv2", bus.rq_readdatavalid, 2'b01);
    step();
    check_val("t5_no_err", err, 1'b0);
    #1;
    check_val("t5_empty_rdv", bus.rq_readdatavalid, 2'b00);
    step();
    bus.avl_readdatavalid = 1'b0;
    check_val("t5_empty_err", err, 1'b1);

    // reset in GRANT with reads outstanding, then a stale response
    apply_reset();
    for (int n = 0; n < 3; n++) issue(0, 1'b1, ADDR_W'(n + 8));
    bus.rq_write      = 2'b10;
    bus.rq_address[1] = 26'h99;
    step();
    check_val("t6_granted", bus.avl_write, 1'b1);
    reset = 1'b1;
    #1;
    check_val("t6_rst_write", bus.avl_write, 1'b0);
    check_val("t6_rst_bb", bus.avl_burstbegin, 1'b0);
    check_val("t6_rst_addr", bus.avl_address, '0);
    check_val("t6_rst_wrn", bus.rq_wait_request_n, 2'b00);
    model_reset();
    bus.rq_write = 2'b00;
    @(posedge iCLK);
    #1;
    reset = 1'b0;
    bus.avl_readdatavalid = 1'b1;
    #1;
    check_val("t6_late_rdv", bus.rq_readdatavalid, 2'b00);
    step();
    bus.avl_readdatavalid = 1'b0;
    check_val("t6_late_err", err, 1'b1);

    // randomized traffic: requesters mostly hold commands until accepted
    apply_reset();
    has[0] = 1'b0;
    has[1] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (acc == i) has[i] = 1'b0;
        if (has[i] && $urandom_range(0, 49) == 0) has[i] = 1'b0;
        if (!has[i] && $urandom_range(0, 2) == 0) begin
          int kind;
          kind    = $urandom_range(0, 9);
          has[i]  = 1'b1;
          isrd[i] = (kind <= 4) || (kind == 9);
          iswr[i] = (kind >= 5);
          bus.rq_address[i]   = ADDR_W'($urandom);
          bus.rq_writedata[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        bus.rq_read[i]  = has[i] && isrd[i];
        bus.rq_write[i] = has[i] && iswr[i];
      end
      bus.avl_wait_request_n = ($urandom_range(0, 3) != 0);
      bus.avl_readdatavalid  = (q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                              : ($urandom_range(0, 99) == 0);
      bus.avl_readdata       = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
